// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle shift/rotate controller for the 16-bit ALU. Accepts one
//   command and applies one bit position per clock until the requested
//   amount has been shifted, then pulses done with result and flags.
//
// Ports
//   clk      in   system clock, rising-edge
//   rst_n    in   synchronous active-low reset
//   start    in   command request, sampled in IDLE or DONE only
//   op       in   000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR (others reserved)
//   amount   in   shift distance, 0..2^AMT_W-1
//   in_data  in   operand
//   busy     out  high while shifting
//   done     out  one-cycle pulse, result/flags valid
//   result   out  working register (shifted value)
//   carry    out  last bit shifted or rotated out
//   zero     out  result == 0
module shift_sequencer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             carry_q, carry_d;
   logic [AMT_W-1:0] count_q, count_d;

   // One 1-bit step: returns {bit shifted out, new value}.
   function automatic logic [WIDTH:0] step_fn(input op_t o, input logic [WIDTH-1:0] v);
      logic [WIDTH:0] r;
      case (o)
         OP_SLL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {v[0], 1'b0, v[WIDTH-1:1]};
         OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
         default: r = {1'b0, v};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_SLL;
         work_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      work_d  = work_q;
      carry_d = carry_q;
      count_d = count_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op_d    = op_t'(op);
               work_d  = in_data;
               carry_d = 1'b0;
               // Zero distance and reserved opcodes complete immediately
               // with the operand passed through unchanged.
               if (amount == '0 || op > 3'b100) begin
                  count_d = '0;
                  state_d = DONE;
               end else begin
                  count_d = amount;
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            {carry_d, work_d} = step_fn(op_q, work_q);
            count_d = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign result = work_q;
   assign carry  = carry_q;
   assign zero   = (work_q == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Directed and randomized stimulus for shift_sequencer, compared every
//   cycle against a behavioural model that computes the shifted value
//   directly from operand, opcode and number of steps taken so far.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [3:0]  amount;
   logic [15:0] in_data;
   logic        busy, done, carry, zero;
   logic [15:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .amount  (amount),
      .in_data (in_data),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .carry   (carry),
      .zero    (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_valid = 1'b0;
   logic [15:0] m_in, m_res;
   logic [2:0]  m_op;
   logic        m_carry, m_done;
   int          m_left, m_k;

   // Value and carry after k single-bit steps (k >= 1).
   task automatic shifted(input logic [15:0] d, input logic [2:0] o, input int k,
                          output logic [15:0] r, output logic c);
      case (o)
         3'd0: begin r = d << k;  c = d[16-k]; end
         3'd1: begin r = d >> k;  c = d[k-1];  end
         3'd2: begin r = 16'($signed(d) >>> k); c = d[k-1]; end
         3'd3: begin r = (d << k) | (d >> (16-k)); c = r[0];  end
         3'd4: begin r = (d >> k) | (d << (16-k)); c = r[15]; end
         default: begin r = d; c = 1'b0; end
      endcase
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b1;
         m_res = '0; m_carry = 1'b0; m_done = 1'b0; m_left = 0; m_k = 0;
      end else if (m_left == 0) begin
         m_done = 1'b0;
         if (start) begin
            m_in = in_data; m_op = op; m_k = 0;
            m_res = in_data; m_carry = 1'b0;
            if (amount == 0 || op > 3'd4) m_done = 1'b1;
            else m_left = int'(amount);
         end
      end else begin
         m_k++;
         m_left--;
         shifted(m_in, m_op, m_k, m_res, m_carry);
         if (m_left == 0) m_done = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy",   32'(busy),   32'(m_left != 0));
         chk("done",   32'(done),   32'(m_done));
         chk("result", 32'(result), 32'(m_res));
         chk("carry",  32'(carry),  32'(m_carry));
         chk("zero",   32'(zero),   32'(m_res == 16'h0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   // Issue one command, then observe 20 cycles. Optionally pulse a second
   // start at observation cycle 'poke' (should be ignored while shifting).
   task automatic cmd(input string nm, input logic [2:0] o, input logic [15:0] d,
                      input logic [3:0] a, input logic [15:0] er, input logic ec,
                      input int elat, input int ebusy, input int poke);
      int lat, nbusy, ndone;
      logic [15:0] r_at;
      logic c_at;
      lat = 0; nbusy = 0; ndone = 0; r_at = 'x; c_at = 1'bx;
      start = 1'b1; op = o; in_data = d; amount = a;
      tick();
      start = 1'b0; op = 'x; in_data = 'x; amount = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (ndone == 1) begin lat = i; r_at = result; c_at = carry; end
         end
         if (i == poke) begin
            start = 1'b1; op = 3'd0; in_data = 16'hFFFF; amount = 4'd3;
         end else begin
            start = 1'b0;
         end
      end
      tick();
      chk({nm, " latency"}, 32'(lat),   32'(elat));
      chk({nm, " busy"},    32'(nbusy), 32'(ebusy));
      chk({nm, " ndone"},   32'(ndone), 32'd1);
      chk({nm, " result"},  32'(r_at),  32'(er));
      chk({nm, " carry"},   32'(c_at),  32'(ec));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; amount = '0; in_data = '0;
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst busy",   32'(busy),   32'd0);
      chk("rst done",   32'(done),   32'd0);
      chk("rst result", 32'(result), 32'd0);
      chk("rst carry",  32'(carry),  32'd0);
      chk("rst zero",   32'(zero),   32'd1);
      tick();

      cmd("sra4",  3'd2, 16'h8001, 4'd4,  16'hF800, 1'b0, 5,  4,  0);
      cmd("rol1",  3'd3, 16'h8001, 4'd1,  16'h0003, 1'b1, 2,  1,  0);
      cmd("srl15", 3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0, 16, 15, 5);
      cmd("sll0",  3'd0, 16'h1234, 4'd0,  16'h1234, 1'b0, 1,  0,  0);
      cmd("rsvd",  3'd6, 16'h00FF, 4'd5,  16'h00FF, 1'b0, 1,  0,  0);

      // Back-to-back: second start presented in the DONE cycle.
      start = 1'b1; op = 3'd4; in_data = 16'h0001; amount = 4'd1;
      tick();
      start = 1'b0;
      tick();
      @(negedge clk);
      chk("b2b done1",   32'(done),   32'd1);
      chk("b2b result1", 32'(result), 32'h8000);
      chk("b2b carry1",  32'(carry),  32'd1);
      chk("b2b zero1",   32'(zero),   32'd0);
      start = 1'b1; op = 3'd0; in_data = 16'h8000; amount = 4'd1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("b2b busy2", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      chk("b2b done2",   32'(done),   32'd1);
      chk("b2b result2", 32'(result), 32'h0000);
      chk("b2b carry2",  32'(carry),  32'd1);
      chk("b2b zero2",   32'(zero),   32'd1);
      tick();
      tick();

      // Reset in the middle of SLL by 8: edge k+3 is the reset edge.
      begin
         int nd;
         start = 1'b1; op = 3'd0; in_data = 16'h00FF; amount = 4'd8;
         tick();
         start = 1'b0;
         tick(); tick();
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
         @(negedge clk);
         chk("abort busy",   32'(busy),   32'd0);
         chk("abort done",   32'(done),   32'd0);
         chk("abort result", 32'(result), 32'd0);
         chk("abort carry",  32'(carry),  32'd0);
         chk("abort zero",   32'(zero),   32'd1);
         nd = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
         end
         chk("abort no done", 32'(nd), 32'd0);
         tick();
         cmd("after rst", 3'd2, 16'h8001, 4'd4, 16'hF800, 1'b0, 5, 4, 0);
      end

      // Randomized traffic, compared every cycle by the model.
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(0, 2) == 0);
         op      = 3'($urandom_range(0, 7));
         amount  = 4'($urandom_range(0, 15));
         in_data = 16'($urandom);
         rst_n   = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst_n = 1'b1; start = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
